aqed_seq_checker: RTL
=====================

AQED_SEQ_CHECKER -- requirements
Module: aqed_seq_checker

Interface
REQ-001 Parameter DATA_W, default 16, data width of every DUT transaction.
REQ-002 Parameter SEQ_DEPTH, default 16, maximum number of original transactions recorded; a power of two, at least 2.
REQ-003 Parameter PTR_W, default $clog2(SEQ_DEPTH)+1, width of the pointers and counters.
REQ-004 clk  in  1  sole clock; every register updates on the rising edge.
REQ-005 reset  in  1  synchronous active-low reset.
REQ-006 clk_en  in  1  global enable; when low, all state holds and dut_in_valid=0.
REQ-007 flush  in  1  synchronous sequence restart, qualified by clk_en.
REQ-008 in_valid / in_data  in  1 / DATA_W  environment transaction offered to the checker.
REQ-009 in_ready  out  1  checker accepts in_valid this cycle.
REQ-010 exec_dup  in  1  request to issue a duplicate.
REQ-011 dup_sel  in  PTR_W-1  index of the original to duplicate; free input for formal.
REQ-012 dut_in_valid / dut_in_data  out  1 / DATA_W  transaction driven to the DUT.
REQ-013 dut_out_valid / dut_out_data  in  1 / DATA_W  in-order DUT result.
REQ-014 seq_pointer  out  PTR_W  count of accepted originals.
REQ-015 dup_issued  out  1  duplicate has been sent.
REQ-016 qed_done / qed_check  out  1 / 1  comparison complete / results matched.

Function
REQ-017 The FSM SHALL use the states ORIG, DUP_ISSUE, DUP_WAIT and DONE, and reset to ORIG.
REQ-018 In ORIG: in_ready = clk_en & ~flush & (seq_pointer < SEQ_DEPTH).
REQ-019 In ORIG: an accept (in_valid & in_ready) stores in_data at index seq_pointer, drives it combinationally on dut_in_*, and increments seq_pointer.
REQ-020 In all other states in_ready SHALL be 0.
REQ-021 Every dut_out_valid (with clk_en) SHALL log dut_out_data at index out_cnt and increment out_cnt, in every state.
REQ-022 ORIG->DUP_ISSUE SHALL occur when exec_dup & clk_en & dup_sel < seq_pointer.
- The seq_pointer value is taken before any same-cycle increment.
- On the transition, dup_idx = dup_sel and dup_pos = seq_pointer are latched, counting the same-cycle accept.
REQ-023 An exec_dup with dup_sel >= seq_pointer, or outside ORIG, SHALL be ignored.
REQ-024 In DUP_ISSUE the block SHALL drive dut_in_valid=1 with stored data[dup_idx] for exactly one cycle, set dup_issued, and move to DUP_WAIT.
REQ-025 In DUP_WAIT, the output logged at index dup_pos SHALL be compared with out_log[dup_idx], and the FSM moves to DONE.
REQ-026 In DONE, qed_done=1 and qed_check holds the comparison result; both are sticky until reset or flush.
REQ-027 Outside DONE, qed_done=0 and qed_check=1, so the property qed_done |-> qed_check is trivially true.
REQ-028 When seq_pointer=SEQ_DEPTH, inputs SHALL stall, while exec_dup remains allowed.
REQ-029 out_cnt SHALL saturate at SEQ_DEPTH+1; excess outputs are dropped.
REQ-030 flush with clk_en in any state SHALL clear the pointers, dup_issued and the qed_* outputs, and return the FSM to ORIG; flush has priority over exec_dup.

Reset
REQ-031 When reset=0 at a clock edge, the state SHALL become ORIG, and seq_pointer, out_cnt, dup_idx, dup_pos, dup_issued and qed_done SHALL all become 0, with qed_check=1.
REQ-032 Storage arrays SHALL NOT be reset.
REQ-033 A reset applied mid-sequence SHALL abandon the sequence with no partial qed_done.

Structure
REQ-034 Package aqed_pkg SHALL hold the state enum aqed_state_t and the default DATA_W and SEQ_DEPTH.
REQ-035 Sub-module aqed_seq_buf, instanced twice, SHALL provide the parametrised write-indexed register array with an async read port, used as the input store and the output log.

Verification
REQ-036 Originals 0x11, 0x22, 0x33 are accepted, then exec_dup with dup_sel=1; the DUT echoes its input -> dut_in_data=0x22 in DUP_ISSUE, then qed_done=1 with qed_check=1.
REQ-037 Same stimulus, but the DUT corrupts its 4th output to 0x23 -> qed_done=1 with qed_check=0.
REQ-038 seq_pointer=2 and exec_dup with dup_sel=2 -> ignored; FSM stays in ORIG.
REQ-039 SEQ_DEPTH=4 with 5 inputs offered -> in_ready=0 on the 5th; a dup with dup_sel=3 still completes.
REQ-040 Flush asserted in DUP_WAIT -> FSM returns to ORIG, seq_pointer=0, qed_done=0, dup_issued=0.
REQ-041 exec_dup in the same cycle as the 3rd accept with dup_sel=2 -> ignored; dup_sel=1 -> dup_pos=3.

Source files
------------

// File: rtl/aqed_pkg.sv
// Shared types and defaults for the A-QED sequence checker.
// Holds the checker FSM encoding and the default transaction width and depth.
package aqed_pkg;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_SEQ_DEPTH = 16;

  typedef enum logic [1:0] {
    ORIG      = 2'd0,
    DUP_ISSUE = 2'd1,
    DUP_WAIT  = 2'd2,
    DONE      = 2'd3
  } aqed_state_t;
endpackage

// File: rtl/aqed_seq_checker_if.sv
// Environment-side and DUT-side transaction bus of the sequence checker.
// The checker uses the slave view; the environment and DUT use the master view.
interface aqed_seq_checker_if
  import aqed_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              dut_in_valid;
  logic [DATA_W-1:0] dut_in_data;
  logic              dut_out_valid;
  logic [DATA_W-1:0] dut_out_data;

  modport master (
    output in_valid, in_data, dut_out_valid, dut_out_data,
    input  in_ready, dut_in_valid, dut_in_data
  );

  modport slave (
    input  in_valid, in_data, dut_out_valid, dut_out_data,
    output in_ready, dut_in_valid, dut_in_data
  );
endinterface

// File: rtl/aqed_seq_buf.sv
// Write-indexed register array with an asynchronous read port; contents are not reset.
// Write lands on the rising edge; read data follows rd_idx combinationally.
module aqed_seq_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/aqed_seq_checker.sv
// A-QED functional-consistency checker: records originals, replays one as a duplicate,
// compares its in-order DUT result with the original's; accepts are combinational to the DUT.
module aqed_seq_checker
  import aqed_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SEQ_DEPTH = DEF_SEQ_DEPTH,
  parameter int PTR_W     = $clog2(SEQ_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                flush,
  aqed_seq_checker_if.slave   bus,
  input  logic                exec_dup,
  input  logic [PTR_W-2:0]    dup_sel,
  output logic [PTR_W-1:0]    seq_pointer,
  output logic                dup_issued,
  output logic                qed_done,
  output logic                qed_check
);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(SEQ_DEPTH);
  localparam logic [PTR_W-1:0] LOG_MAX = PTR_W'(SEQ_DEPTH + 1);

  aqed_state_t       state, state_nxt;
  logic [PTR_W-1:0]  out_cnt, dup_pos;
  logic [PTR_W-2:0]  dup_idx;
  logic [DATA_W-1:0] orig_dat, log_dat, dup_out;
  logic              dup_out_vld, check_r;
  logic              in_rdy, accept, log_wr, dup_ok, clear;

  assign clear  = clk_en & flush;
  assign in_rdy = (state == ORIG) & clk_en & ~flush & (seq_pointer < DEPTH_P);
  assign accept = bus.in_valid & in_rdy;
  assign log_wr = clk_en & ~flush & bus.dut_out_valid & (out_cnt < LOG_MAX);
  // Compared against the pointer before this cycle's accept lands.
  assign dup_ok = exec_dup & clk_en & ~flush & ({1'b0, dup_sel} < seq_pointer);

  aqed_seq_buf #(.DATA_W(DATA_W), .DEPTH(SEQ_DEPTH), .IDX_W(PTR_W-1)) u_store (
    .clk     (clk),
    .wr_en   (accept),
    .wr_idx  (seq_pointer[PTR_W-2:0]),
    .wr_data (bus.in_data),
    .rd_idx  (dup_idx),
    .rd_data (orig_dat)
  );

  aqed_seq_buf #(.DATA_W(DATA_W), .DEPTH(SEQ_DEPTH+1), .IDX_W(PTR_W)) u_log (
    .clk     (clk),
    .wr_en   (log_wr),
    .wr_idx  (out_cnt),
    .wr_data (bus.dut_out_data),
    .rd_idx  ({1'b0, dup_idx}),
    .rd_data (log_dat)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ORIG;
    else if (clk_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ORIG;
    end else begin
      case (state)
        ORIG:      if (dup_ok) state_nxt = DUP_ISSUE;
        DUP_ISSUE: state_nxt = DUP_WAIT;
        DUP_WAIT:  if (dup_out_vld) state_nxt = DONE;
        default:   state_nxt = state;
      endcase
    end
  end

  always_comb begin
    bus.in_ready     = 1'b0;
    bus.dut_in_valid = 1'b0;
    bus.dut_in_data  = bus.in_data;
    qed_done         = 1'b0;
    qed_check        = 1'b1;
    case (state)
      ORIG: begin
        bus.in_ready     = in_rdy;
        bus.dut_in_valid = accept;
      end
      DUP_ISSUE: begin
        bus.dut_in_valid = clk_en & ~flush;
        bus.dut_in_data  = orig_dat;
      end
      DONE: begin
        qed_done  = 1'b1;
        qed_check = check_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      seq_pointer <= '0;
      out_cnt     <= '0;
      dup_idx     <= '0;
      dup_pos     <= '0;
      dup_issued  <= 1'b0;
      dup_out_vld <= 1'b0;
      check_r     <= 1'b1;
    end else if (clk_en) begin
      if (accept) seq_pointer <= seq_pointer + PTR_W'(1);
      if (log_wr) out_cnt <= out_cnt + PTR_W'(1);
      if (state == ORIG && dup_ok) begin
        dup_idx <= dup_sel;
        dup_pos <= seq_pointer + PTR_W'(accept);
      end
      if (state == DUP_ISSUE) dup_issued <= 1'b1;
      // The duplicate's result may arrive already in the issue cycle.
      if (state != ORIG && log_wr && out_cnt == dup_pos) dup_out_vld <= 1'b1;
      if (state == DUP_WAIT && dup_out_vld) check_r <= (dup_out == log_dat);
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && state != ORIG && log_wr && out_cnt == dup_pos) dup_out <= bus.dut_out_data;
  end
endmodule
